// File: rtl/aggTypes.sv
// Shared types for the join hit-reduction path: bitmap geometry, FSM states
// and the per-probe hit metadata carried on the s_meta stream.
package aggTypes;

  localparam int BMAP_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } join_state_t;

  typedef struct packed {
    logic hit;
  } hit_meta_t;

endpackage

// File: rtl/AXI4SR.sv
// AXI4-Stream subset used for bitmap words: tdata, tkeep, tlast, handshake.
interface AXI4SR #(
  parameter int DATA_W = 64
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;

  modport m (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport s (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/metaIntf.sv
// Valid/ready stream carrying one hit bit per probe from the join stage.
interface metaIntf;

  logic               valid;
  logic               ready;
  aggTypes::hit_meta_t data;

  modport s (input valid, input data, output ready);
  modport m (output valid, output data, input ready);

endinterface

// File: rtl/join_bitmap_packer.sv
// Packs per-query match bits LSB-first into bitmap words and holds each
// completed word in the m_axis output register until it handshakes.
module join_bitmap_packer #(
  parameter int WORD_W = 64
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_val,
  input  logic last_query,
  output logic word_pend,
  AXI4SR.m     m_axis
);

  localparam int KW = WORD_W / 8;
  localparam int IW = $clog2(WORD_W);
  localparam int NW = IW + 1;

  logic [WORD_W-1:0] bitmap_r;
  logic [WORD_W-1:0] bitmap_nxt_s;
  logic [IW-1:0]     bit_idx_r;
  logic              pend_r;
  logic              tvalid_r;
  logic              tlast_r;
  logic [WORD_W-1:0] tdata_r;
  logic [KW-1:0]     tkeep_r;
  logic              word_done_s;
  logic              hs_s;
  logic [NW-1:0]     nbits_s;
  logic [KW-1:0]     keep_s;

  // Byte i carries data when the word holds more than 8*i valid bits.
  function automatic logic [KW-1:0] keep_from_nbits(input logic [NW-1:0] nbits);
    logic [KW-1:0] keep_v;
    keep_v = {KW{1'b0}};
    for (int i = 0; i < KW; i++) begin
      keep_v[i] = (nbits > NW'(8 * i));
    end
    return keep_v;
  endfunction

  // Next bitmap value, word completion and output handshake decode.
  always_comb begin
    bitmap_nxt_s            = bitmap_r;
    bitmap_nxt_s[bit_idx_r] = bit_val;
    word_done_s             = bit_valid && ((bit_idx_r == IW'(WORD_W - 1)) || last_query);
    nbits_s                 = {1'b0, bit_idx_r} + NW'(1);
    keep_s                  = keep_from_nbits(nbits_s);
    hs_s                    = tvalid_r && m_axis.tready;
  end

  // Bitmap accumulation and the held output word; a handshake and a new bit
  // never coincide because the input is stalled while a word is pending.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bitmap_r  <= {WORD_W{1'b0}};
      bit_idx_r <= {IW{1'b0}};
      pend_r    <= 1'b0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= {WORD_W{1'b0}};
      tkeep_r   <= {KW{1'b0}};
    end else if (clear || hs_s) begin
      bitmap_r  <= {WORD_W{1'b0}};
      bit_idx_r <= {IW{1'b0}};
      pend_r    <= 1'b0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= {WORD_W{1'b0}};
      tkeep_r   <= {KW{1'b0}};
    end else if (bit_valid) begin
      bitmap_r  <= bitmap_nxt_s;
      bit_idx_r <= bit_idx_r + IW'(1);
      if (word_done_s) begin
        pend_r   <= 1'b1;
        tvalid_r <= 1'b1;
        tdata_r  <= bitmap_nxt_s;
        tkeep_r  <= keep_s;
        tlast_r  <= last_query;
      end
    end
  end

  assign word_pend     = pend_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tkeep  = tkeep_r;
  assign m_axis.tlast  = tlast_r;

endmodule

// File: rtl/join_hit_reduce.sv
// OR-reduces each group of table_len join hits into one match bit per query
// and streams the packed bitmap. Optional counters under JOIN_HIT_STATS_EN.
module join_hit_reduce #(
  parameter int TLEN_BITS = 16,
  parameter int QCNT_BITS = 32,
  parameter int BMAP_W    = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_start,
  input  logic [TLEN_BITS-1:0] cfg_table_len,
  input  logic [QCNT_BITS-1:0] cfg_query_cnt,
  output logic                 busy,
`ifdef JOIN_HIT_STATS_EN
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_matches,
`endif
  metaIntf.s                   s_meta,
  AXI4SR.m                     m_axis
);

  import aggTypes::*;

  join_state_t          state_r;
  join_state_t          state_nxt_s;
  logic [TLEN_BITS-1:0] table_len_r;
  logic [TLEN_BITS-1:0] probe_cnt_r;
  logic [QCNT_BITS-1:0] query_cnt_r;
  logic [QCNT_BITS-1:0] q_done_r;
  logic                 acc_r;
  logic                 busy_r;
  logic                 start_ok_s;
  logic                 ready_s;
  logic                 beat_s;
  logic                 last_probe_s;
  logic                 q_fin_s;
  logic                 last_query_s;
  logic                 match_s;
  logic                 hit_s;
  logic                 word_pend_s;
  logic                 final_hs_s;

  assign hit_s = s_meta.data.hit;

  // Beat acceptance and query/batch completion decode.
  always_comb begin
    start_ok_s   = (state_r == IDLE) && cfg_start &&
                   (cfg_table_len != {TLEN_BITS{1'b0}}) && (cfg_query_cnt != {QCNT_BITS{1'b0}});
    beat_s       = ready_s && s_meta.valid;
    last_probe_s = (probe_cnt_r == table_len_r - TLEN_BITS'(1));
    match_s      = acc_r | hit_s;
    q_fin_s      = beat_s && last_probe_s;
    last_query_s = q_fin_s && ((q_done_r + QCNT_BITS'(1)) == query_cnt_r);
    final_hs_s   = m_axis.tvalid && m_axis.tready && m_axis.tlast;
  end

  // FSM state register; busy follows the next state so it drops with the final handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s)   state_nxt_s = RUN;   else state_nxt_s = IDLE;
      RUN:     if (last_query_s) state_nxt_s = DRAIN; else state_nxt_s = RUN;
      DRAIN:   if (final_hs_s)   state_nxt_s = IDLE;  else state_nxt_s = DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: input accepted only while running with no word waiting.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      RUN:     ready_s = !word_pend_s;
      default: ready_s = 1'b0;
    endcase
  end

  assign busy         = busy_r;
  assign s_meta.ready = ready_s;

  // Config latch plus per-query probe counter and OR accumulator.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      table_len_r <= {TLEN_BITS{1'b0}};
      query_cnt_r <= {QCNT_BITS{1'b0}};
      probe_cnt_r <= {TLEN_BITS{1'b0}};
      q_done_r    <= {QCNT_BITS{1'b0}};
      acc_r       <= 1'b0;
    end else if (start_ok_s) begin
      table_len_r <= cfg_table_len;
      query_cnt_r <= cfg_query_cnt;
      probe_cnt_r <= {TLEN_BITS{1'b0}};
      q_done_r    <= {QCNT_BITS{1'b0}};
      acc_r       <= 1'b0;
    end else if (beat_s) begin
      if (last_probe_s) begin
        probe_cnt_r <= {TLEN_BITS{1'b0}};
        q_done_r    <= q_done_r + QCNT_BITS'(1);
        acc_r       <= 1'b0;
      end else begin
        probe_cnt_r <= probe_cnt_r + TLEN_BITS'(1);
        acc_r       <= match_s;
      end
    end
  end

  join_bitmap_packer #(
    .WORD_W (BMAP_W)
  ) u_packer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clear      (start_ok_s),
    .bit_valid  (q_fin_s),
    .bit_val    (match_s),
    .last_query (last_query_s),
    .word_pend  (word_pend_s),
    .m_axis     (m_axis)
  );

`ifdef JOIN_HIT_STATS_EN
  logic [31:0] stat_hits_r;
  logic [31:0] stat_matches_r;

  // Saturating batch statistics, cleared by an accepted start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_hits_r    <= 32'd0;
      stat_matches_r <= 32'd0;
    end else if (start_ok_s) begin
      stat_hits_r    <= 32'd0;
      stat_matches_r <= 32'd0;
    end else begin
      if (beat_s && hit_s && (stat_hits_r != 32'hFFFF_FFFF)) begin
        stat_hits_r <= stat_hits_r + 32'd1;
      end
      if (q_fin_s && match_s && (stat_matches_r != 32'hFFFF_FFFF)) begin
        stat_matches_r <= stat_matches_r + 32'd1;
      end
    end
  end

  assign stat_hits    = stat_hits_r;
  assign stat_matches = stat_matches_r;
`endif

endmodule

// File: tb/tb_join_hit_reduce.sv
// Scoreboard bench for join_hit_reduce: directed hit patterns push expected
// bitmap words; an independent monitor pops and compares on each handshake.
module tb_join_hit_reduce;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  logic        aclk;
  logic        aresetn;
  logic        cfg_start;
  logic [15:0] cfg_table_len;
  logic [31:0] cfg_query_cnt;
  logic        busy;
`ifdef JOIN_HIT_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_matches;
`endif

  metaIntf meta_if();
  AXI4SR #(.DATA_W(64)) axis_if();

  word_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  join_hit_reduce #(
    .TLEN_BITS (16),
    .QCNT_BITS (32),
    .BMAP_W    (64)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_table_len (cfg_table_len),
    .cfg_query_cnt (cfg_query_cnt),
    .busy          (busy),
`ifdef JOIN_HIT_STATS_EN
    .stat_hits     (stat_hits),
    .stat_matches  (stat_matches),
`endif
    .s_meta        (meta_if),
    .m_axis        (axis_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Called #1 after a rising edge; leaves the same phase.
  task automatic start(input logic [15:0] tl, input logic [31:0] qc);
    cfg_table_len = tl;
    cfg_query_cnt = qc;
    cfg_start     = 1'b1;
    @(posedge aclk); #1;
    cfg_start     = 1'b0;
  endtask

  task automatic send_hit(input logic h);
    int n = 0;
    meta_if.valid    = 1'b1;
    meta_if.data.hit = h;
    @(negedge aclk);
    while (!meta_if.ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: ready low for %0d cycles, expected high", n);
    end
    @(posedge aclk); #1;
    meta_if.valid = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic [63:0] bits);
    for (int i = 0; i < n; i++) send_hit(bits[i]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    check(name, 64'(n >= 2000), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // Monitor: compares every presented word against the scoreboard head.
  initial begin : monitor
    word_t w;
    forever begin
      @(negedge aclk);
      if (aresetn && axis_if.tvalid && axis_if.tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected none", axis_if.tdata);
        end else begin
          w = exp_q.pop_front();
          check("tdata", axis_if.tdata, w.data);
          check("tkeep", 64'(axis_if.tkeep), 64'(w.keep));
          check("tlast", 64'(axis_if.tlast), 64'(w.last));
          if (w.last) begin
            check("busy_at_last_hs", 64'(busy), 64'd1);
            @(negedge aclk);
            check("busy_after_last_hs", 64'(busy), 64'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    aresetn          = 1'b0;
    cfg_start        = 1'b0;
    cfg_table_len    = 16'd0;
    cfg_query_cnt    = 32'd0;
    meta_if.valid    = 1'b0;
    meta_if.data.hit = 1'b0;
    axis_if.tready   = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy",   64'(busy),           64'd0);
    check("rst_ready",  64'(meta_if.ready),  64'd0);
    check("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
    check("rst_tlast",  64'(axis_if.tlast),  64'd0);
    check("rst_tkeep",  64'(axis_if.tkeep),  64'd0);
    check("rst_tdata",  axis_if.tdata,       64'd0);
    @(posedge aclk); #1;
    aresetn        = 1'b1;
    axis_if.tready = 1'b1;
    @(posedge aclk); #1;

    // table_len=4, query_cnt=3, hits 0001 0000 1100
    push_word(64'h5, 8'h01, 1'b1);
    start(16'd4, 32'd3);
    send_bits(12, 64'h308);
    wait_done("t1_done");
`ifdef JOIN_HIT_STATS_EN
    check("t1_stat_hits",    64'(stat_hits),    64'd3);
    check("t1_stat_matches", 64'(stat_matches), 64'd2);
`endif

    // table_len=1, query_cnt=64, all hits -> one full word
    push_word(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    start(16'd1, 32'd64);
    send_bits(64, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("t2_done");

    // table_len=2, query_cnt=70, even queries match; stall the first word
    axis_if.tready = 1'b0;
    push_word(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    push_word(64'h15, 8'h01, 1'b1);
    start(16'd2, 32'd70);
    fork
      begin
        for (int k = 0; k < 70; k++) begin
          send_hit(1'b0);
          send_hit((k % 2) == 0);
        end
      end
      begin
        n = 0;
        while (!axis_if.tvalid && n < 1000) begin
          @(negedge aclk);
          n++;
        end
        check("stall_seen", 64'(axis_if.tvalid), 64'd1);
        for (int i = 0; i < 10; i++) begin
          @(negedge aclk);
          check("stall_ready",  64'(meta_if.ready),  64'd0);
          check("stall_tvalid", 64'(axis_if.tvalid), 64'd1);
          check("stall_tdata",  axis_if.tdata,       64'h5555_5555_5555_5555);
          check("stall_tkeep",  64'(axis_if.tkeep),  64'hFF);
          check("stall_tlast",  64'(axis_if.tlast),  64'd0);
        end
        @(posedge aclk); #1;
        axis_if.tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("resume_ready", 64'(meta_if.ready), 64'd1);
      end
    join
    wait_done("t3_done");

    // Ignored starts: zero table_len, zero query_cnt, and a start while busy
    start(16'd0, 32'd5);
    @(negedge aclk);
    check("ign_tl0_busy",  64'(busy),          64'd0);
    check("ign_tl0_ready", 64'(meta_if.ready), 64'd0);
    @(posedge aclk); #1;
    start(16'd3, 32'd0);
    @(negedge aclk);
    check("ign_qc0_busy",  64'(busy),          64'd0);
    check("ign_qc0_ready", 64'(meta_if.ready), 64'd0);
    @(posedge aclk); #1;
    push_word(64'h2, 8'h01, 1'b1);
    start(16'd3, 32'd2);
    @(negedge aclk);
    check("start_busy",  64'(busy),          64'd1);
    check("start_ready", 64'(meta_if.ready), 64'd1);
    @(posedge aclk); #1;
    start(16'd1, 32'd1);
    send_bits(6, 64'h10);
    wait_done("t4_done");

    // Reset with a word pending: discarded, then a fresh batch works
    axis_if.tready = 1'b0;
    start(16'd1, 32'd100);
    send_bits(64, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge aclk);
    check("pend_before_rst", 64'(axis_if.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 64'(axis_if.tvalid), 64'd0);
    check("midrst_busy",   64'(busy),           64'd0);
    check("midrst_ready",  64'(meta_if.ready),  64'd0);
    check("midrst_tdata",  axis_if.tdata,       64'd0);
    @(posedge aclk); #1;
    aresetn        = 1'b1;
    axis_if.tready = 1'b1;
    @(posedge aclk); #1;
    push_word(64'h1, 8'h01, 1'b1);
    start(16'd2, 32'd2);
    send_bits(4, 64'h1);
    wait_done("t5_done");
`ifdef JOIN_HIT_STATS_EN
    check("t5_stat_hits",    64'(stat_hits),    64'd1);
    check("t5_stat_matches", 64'(stat_matches), 64'd1);
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
